// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and constants for the two-port memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_READ   = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Purpose: bundles both requester ports and the RAM-side bus of the arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req/we/addr/wdata until their ack pulse.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic [DATA_W-1:0] mem_dout;

  // Arbiter side.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output ack0, ack1, rdata0, rdata1, mem_addr, mem_din, mem_we
  );

  // Requesters plus RAM side.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  ack0, ack1, rdata0, rdata1, mem_addr, mem_din, mem_we
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Purpose: combinational 2-way winner selection (fixed priority or round-robin).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when the pick is used.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int RR_MODE = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic any_req,
  output logic winner
);

  // Tie goes to port 0 in fixed mode, to the port not granted last in RR mode.
  always_comb begin
    any_req = req0 | req1;
    winner  = PORT_CPU;
    if (req0 && req1) begin
      winner = (RR_MODE != 0) ? ~last_grant : PORT_CPU;
    end else if (req1) begin
      winner = PORT_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates CPU and DMA ports onto one 1024x8 synchronous RAM.
// Latency: req in IDLE cycle t -> ack in t+3; one access every 4 cycles.
// Backpressure: reqs only sampled in IDLE; loser keeps req high until served.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RR_MODE = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

  state_t            state_q;
  state_t            state_d;
  // grant_q doubles as the last-grant record for round-robin; it resets to
  // the DMA port so the first tie after reset goes to the CPU.
  logic              grant_q;
  logic              gwe_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              any_req;
  logic              winner;
  logic              mem_we_c;
  logic              ack0_c;
  logic              ack1_c;

  mem_arb_pick #(
    .RR_MODE    (RR_MODE)
  ) u_pick (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (grant_q),
    .any_req    (any_req),
    .winner     (winner)
  );

  // State register; async reset aborts any in-flight access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus state-decoded strobes (write enable and ack pulses).
  always_comb begin
    state_d  = state_q;
    mem_we_c = 1'b0;
    ack0_c   = 1'b0;
    ack1_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d  = ST_READ;
        mem_we_c = gwe_q;
      end
      ST_READ: begin
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        ack0_c  = (grant_q == PORT_CPU);
        ack1_c  = (grant_q == PORT_DMA);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch the winner's request on the IDLE->ACCESS edge; held until next grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q <= PORT_DMA;
      gwe_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else if (state_q == ST_IDLE && any_req) begin
      grant_q <= winner;
      if (winner == PORT_DMA) begin
        gwe_q  <= bus.we1;
        addr_q <= bus.addr1;
        din_q  <= bus.wdata1;
      end else begin
        gwe_q  <= bus.we0;
        addr_q <= bus.addr0;
        din_q  <= bus.wdata0;
      end
    end
  end

  // RAM output is valid in READ; capture it for the granted port only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state_q == ST_READ) begin
      if (grant_q == PORT_CPU) begin
        rdata0_q <= bus.mem_dout;
      end else begin
        rdata1_q <= bus.mem_dout;
      end
    end
  end

  assign bus.mem_we   = mem_we_c;
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = din_q;
  assign bus.ack0     = ack0_c;
  assign bus.ack1     = ack1_c;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;

endmodule
